alu_sequencer: RTL and testbench

ALU_SEQUENCER -- requirements
Module: alu_sequencer

---
 rtl/alu_sequencer_if.sv | 35 +++
 rtl/alu_sequencer.sv | 102 ++++++++++
 tb/tb_alu_sequencer.sv | 245 ++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_sequencer_if.sv
// Handshake, load, ALU and debug signals of alu_sequencer grouped into one bundle.
// Signal suffixes (_i/_o) are written from the sequencer's point of view.
interface alu_sequencer_if;
  logic        start_i;
  logic [11:0] instr_i;
  logic        ld_en_i;
  logic [2:0]  ld_addr_i;
  logic [15:0] ld_data_i;
  logic [2:0]  alu_op_o;
  logic [15:0] alu_a_o;
  logic [15:0] alu_b_o;
  logic [15:0] alu_y_i;
  logic        alu_carry_i;
  logic        alu_zero_i;
  logic        busy_o;
  logic        done_o;
  logic        flag_c_o;
  logic        flag_z_o;
  logic [2:0]  dbg_addr_i;
  logic [15:0] dbg_data_o;

  modport slave (
    input  start_i, instr_i, ld_en_i, ld_addr_i, ld_data_i,
    input  alu_y_i, alu_carry_i, alu_zero_i, dbg_addr_i,
    output alu_op_o, alu_a_o, alu_b_o, busy_o, done_o,
    output flag_c_o, flag_z_o, dbg_data_o
  );

  modport master (
    output start_i, instr_i, ld_en_i, ld_addr_i, ld_data_i,
    output alu_y_i, alu_carry_i, alu_zero_i, dbg_addr_i,
    input  alu_op_o, alu_a_o, alu_b_o, busy_o, done_o,
    input  flag_c_o, flag_z_o, dbg_data_o
  );
endinterface

// File: rtl/alu_sequencer.sv
// Five-state sequencer driving an external ALU from an 8 x 16 register file.
// One instruction in flight: IDLE -> FETCH -> EXEC -> WRITE -> DONE -> IDLE.
module alu_sequencer (
  input  logic            clk,
  input  logic            rst,
  alu_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FETCH = 3'd1,
    S_EXEC  = 3'd2,
    S_WRITE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q;
  logic [15:0] rf_q [8];
  logic [11:0] instr_q;
  logic [15:0] opnd_a_q;
  logic [15:0] opnd_b_q;
  logic [15:0] result_q;
  logic        c_q;
  logic        z_q;
  logic        flag_c_q;
  logic        flag_z_q;
  logic        busy_q;
  logic        done_q;

  // ALU drive comes only from registers, so it holds steady through EXEC and WRITE.
  assign bus.alu_op_o   = instr_q[11:9];
  assign bus.alu_a_o    = opnd_a_q;
  assign bus.alu_b_o    = opnd_b_q;
  assign bus.busy_o     = busy_q;
  assign bus.done_o     = done_q;
  assign bus.flag_c_o   = flag_c_q;
  assign bus.flag_z_o   = flag_z_q;
  assign bus.dbg_data_o = rf_q[bus.dbg_addr_i];

  // Sequencer state, register file and all registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      for (int i = 0; i < 8; i++) begin
        rf_q[i] <= 16'h0000;
      end
      instr_q  <= 12'h000;
      opnd_a_q <= 16'h0000;
      opnd_b_q <= 16'h0000;
      result_q <= 16'h0000;
      c_q      <= 1'b0;
      z_q      <= 1'b0;
      flag_c_q <= 1'b0;
      flag_z_q <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          // A load on the start edge lands before FETCH reads the file.
          if (bus.ld_en_i) begin
            rf_q[bus.ld_addr_i] <= bus.ld_data_i;
          end
          if (bus.start_i) begin
            instr_q <= bus.instr_i;
            busy_q  <= 1'b1;
            state_q <= S_FETCH;
          end
        end
        S_FETCH: begin
          opnd_a_q <= rf_q[instr_q[5:3]];
          opnd_b_q <= rf_q[instr_q[2:0]];
          state_q  <= S_EXEC;
        end
        S_EXEC: begin
          result_q <= bus.alu_y_i;
          c_q      <= bus.alu_carry_i;
          z_q      <= bus.alu_zero_i;
          state_q  <= S_WRITE;
        end
        S_WRITE: begin
          rf_q[instr_q[8:6]] <= result_q;
          flag_c_q <= c_q;
          flag_z_q <= z_q;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_sequencer.sv
// Directed bench for alu_sequencer: a reference ALU, a latency/register-file model
// checked every cycle, and literal expectations for the documented scenarios.
module tb_alu_sequencer;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  alu_sequencer_if bus ();

  alu_sequencer dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_done   = 0;

  // Reference ALU: returns {carry, y}; carry is borrow for sub, 0 for non-arithmetic ops.
  function automatic logic [16:0] ref_alu(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
    case (op)
      3'b000:  return {1'b0, a} + {1'b0, b};
      3'b001:  return {(a < b), a - b};
      3'b010:  return {1'b0, a[14:0], 1'b0};
      3'b011:  return {1'b0, a[0], a[15:1]};
      3'b100:  return {1'b0, a & b};
      3'b101:  return {1'b0, a | b};
      3'b110:  return {1'b0, a ^ b};
      default: return {1'b0, ~a};
    endcase
  endfunction

  logic [16:0] alu_r;
  assign alu_r           = ref_alu(bus.alu_op_o, bus.alu_a_o, bus.alu_b_o);
  assign bus.alu_y_i     = alu_r[15:0];
  assign bus.alu_carry_i = alu_r[16];
  assign bus.alu_zero_i  = (alu_r[15:0] == 16'h0000);

  task automatic check16(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic check1(input string nm, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Model: an accepted instruction retires 3 edges after the start edge, then shows done for one cycle.
  logic [15:0] m_rf [8];
  int          m_phase;
  logic [2:0]  m_op, m_rd;
  logic [15:0] m_a, m_b;
  logic        m_fc, m_fz;
  logic [16:0] m_res;
  assign m_res = ref_alu(m_op, m_a, m_b);

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 8; i++) m_rf[i] <= 16'h0000;
      m_phase <= 0;
      m_op <= 3'd0; m_rd <= 3'd0; m_a <= 16'h0000; m_b <= 16'h0000;
      m_fc <= 1'b0; m_fz <= 1'b0;
    end else begin
      case (m_phase)
        0: begin
          if (bus.ld_en_i) m_rf[bus.ld_addr_i] <= bus.ld_data_i;
          if (bus.start_i) begin
            m_op <= bus.instr_i[11:9];
            m_rd <= bus.instr_i[8:6];
            m_a  <= (bus.ld_en_i && bus.ld_addr_i == bus.instr_i[5:3]) ? bus.ld_data_i : m_rf[bus.instr_i[5:3]];
            m_b  <= (bus.ld_en_i && bus.ld_addr_i == bus.instr_i[2:0]) ? bus.ld_data_i : m_rf[bus.instr_i[2:0]];
            m_phase <= 1;
          end
        end
        1, 2: m_phase <= m_phase + 1;
        3: begin
          m_rf[m_rd] <= m_res[15:0];
          m_fc <= m_res[16];
          m_fz <= (m_res[15:0] == 16'h0000);
          m_phase <= 4;
        end
        default: m_phase <= 0;
      endcase
    end
  end

  // Per-cycle compare, sampled mid-high-phase away from both clock edges.
  always @(posedge clk) begin
    #4;
    if (bus.done_o) n_done++;
    if (!rst) begin
      check1 ("busy",     bus.busy_o,     (m_phase != 0));
      check1 ("done",     bus.done_o,     (m_phase == 4));
      check1 ("flag_c",   bus.flag_c_o,   m_fc);
      check1 ("flag_z",   bus.flag_z_o,   m_fz);
      check16("dbg_data", bus.dbg_data_o, m_rf[bus.dbg_addr_i]);
      if (m_phase == 2) begin
        check16("alu_op", {13'd0, bus.alu_op_o}, {13'd0, m_op});
        check16("alu_a",  bus.alu_a_o, m_a);
        check16("alu_b",  bus.alu_b_o, m_b);
      end
    end
  end

  task automatic peek(input string nm, input logic [2:0] r, input logic [15:0] exp);
    bus.dbg_addr_i = r;
    #1;
    check16(nm, bus.dbg_data_o, exp);
  endtask

  task automatic load(input logic [2:0] a, input logic [15:0] d);
    bus.ld_en_i = 1'b1; bus.ld_addr_i = a; bus.ld_data_i = d;
    @(negedge clk);
    bus.ld_en_i = 1'b0;
  endtask

  // Issue one instruction (optionally with a load on the same edge, or a stray start+load in EXEC).
  task automatic run(input logic [2:0] op, input logic [2:0] rd, input logic [2:0] ra, input logic [2:0] rb,
                     input bit with_ld, input logic [2:0] la, input logic [15:0] ld, input bit inject);
    int lat;
    bus.instr_i = {op, rd, ra, rb};
    bus.start_i = 1'b1;
    bus.ld_en_i = with_ld; bus.ld_addr_i = la; bus.ld_data_i = ld;
    bus.dbg_addr_i = rd;
    @(negedge clk);
    lat = 1;
    bus.start_i = 1'b0; bus.ld_en_i = 1'b0;
    while (!bus.done_o && lat < 12) begin
      if (inject && lat == 2) begin
        bus.start_i = 1'b1; bus.ld_en_i = 1'b1; bus.ld_addr_i = 3'd0; bus.ld_data_i = 16'h1234;
      end else begin
        bus.start_i = 1'b0; bus.ld_en_i = 1'b0;
      end
      @(negedge clk);
      lat++;
    end
    bus.start_i = 1'b0; bus.ld_en_i = 1'b0;
    check16("latency", lat[15:0], 16'd4);
    @(negedge clk);
  endtask

  initial begin
    int d0;
    rst = 1'b1;
    bus.start_i = 1'b0; bus.instr_i = 12'h000; bus.ld_en_i = 1'b0;
    bus.ld_addr_i = 3'd0; bus.ld_data_i = 16'h0000; bus.dbg_addr_i = 3'd0;
    @(negedge clk);
    #1;
    check1 ("rst_busy",   bus.busy_o,   1'b0);
    check1 ("rst_done",   bus.done_o,   1'b0);
    check1 ("rst_flag_c", bus.flag_c_o, 1'b0);
    check1 ("rst_flag_z", bus.flag_z_o, 1'b0);
    check16("rst_alu_op", {13'd0, bus.alu_op_o}, 16'h0000);
    check16("rst_alu_a",  bus.alu_a_o, 16'h0000);
    check16("rst_alu_b",  bus.alu_b_o, 16'h0000);
    for (int i = 0; i < 8; i++) peek("rst_rf", i[2:0], 16'h0000);
    @(negedge clk);
    rst = 1'b0;

    // add FFFF + 0001
    load(3'd1, 16'hFFFF);
    load(3'd2, 16'h0001);
    run(3'b000, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0000, 1'b0);
    peek("add_R3", 3'd3, 16'h0000);
    check1("add_c", bus.flag_c_o, 1'b1);
    check1("add_z", bus.flag_z_o, 1'b1);

    // sub 0005 - 0007
    load(3'd1, 16'h0005);
    load(3'd2, 16'h0007);
    run(3'b001, 3'd4, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0000, 1'b0);
    peek("sub_R4", 3'd4, 16'hFFFE);
    check1("sub_c", bus.flag_c_o, 1'b1);
    check1("sub_z", bus.flag_z_o, 1'b0);

    // shl in place, then ror
    load(3'd5, 16'h8001);
    run(3'b010, 3'd5, 3'd5, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0);
    peek("shl_R5", 3'd5, 16'h0002);
    check1("shl_c", bus.flag_c_o, 1'b0);
    load(3'd7, 16'h0001);
    run(3'b011, 3'd6, 3'd7, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0);
    peek("ror_R6", 3'd6, 16'h8000);

    // stray start and load while busy are dropped
    d0 = n_done;
    run(3'b000, 3'd3, 3'd1, 3'd2, 1'b0, 3'd0, 16'h0000, 1'b1);
    repeat (3) @(negedge clk);
    check16("ignored_done_cnt", 16'(n_done - d0), 16'd1);
    peek("ignored_R0", 3'd0, 16'h0000);
    peek("ignored_R3", 3'd3, 16'h000C);
    check1("ignored_busy", bus.busy_o, 1'b0);

    // set flag_z so the reset clear below is observable
    run(3'b100, 3'd7, 3'd0, 3'd0, 1'b0, 3'd0, 16'h0000, 1'b0);
    check1("and_z", bus.flag_z_o, 1'b1);

    // xor aborted by reset in WRITE
    load(3'd2, 16'h5A5A);
    d0 = n_done;
    bus.instr_i = {3'b110, 3'd2, 3'd1, 3'd3};
    bus.start_i = 1'b1;
    bus.dbg_addr_i = 3'd2;
    repeat (3) begin
      @(negedge clk);
      bus.start_i = 1'b0;
    end
    rst = 1'b1;
    #1;
    check1 ("abort_busy",   bus.busy_o,     1'b0);
    check1 ("abort_done",   bus.done_o,     1'b0);
    check1 ("abort_flag_c", bus.flag_c_o,   1'b0);
    check1 ("abort_flag_z", bus.flag_z_o,   1'b0);
    check16("abort_R2",     bus.dbg_data_o, 16'h0000);
    repeat (2) @(negedge clk);
    check16("abort_done_cnt", 16'(n_done - d0), 16'd0);

    // first edge after release: load R6 and start not R6 on the same edge
    rst = 1'b0;
    run(3'b111, 3'd1, 3'd6, 3'd0, 1'b1, 3'd6, 16'h00FF, 1'b0);
    peek("not_R1", 3'd1, 16'hFF00);
    check1("not_c", bus.flag_c_o, 1'b0);
    check1("not_z", bus.flag_z_o, 1'b0);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation still running at %0t, expected completion", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
